// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory-bus bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 16
) ();
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read_en;
   logic              mem_write_en;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;
   logic              busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
      output if_rdata, if_ack, dm_rdata, dm_ack,
             mem_address, mem_read_en, mem_write_en, mem_data_in, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
      input  if_rdata, if_ack, dm_rdata, dm_ack,
             mem_address, mem_read_en, mem_write_en, mem_data_in, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access (IDLE->ACCESS->RESP).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed DM priority with IF starvation guard.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 13,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              sel_dm_q, sel_dm_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              grant_dm;

`ifdef MEM_ARB_RR_EN
   logic rr_last_dm_q, rr_last_dm_d;
`else
   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
   logic [SW-1:0] starve_q, starve_d;
`endif

   // Winner when the IDLE edge sees at least one request.
   always_comb begin
      grant_dm = bus.dm_req;
      if (bus.dm_req && bus.if_req) begin
`ifdef MEM_ARB_RR_EN
         grant_dm = !rr_last_dm_q;
`else
         grant_dm = (starve_q != LIM);
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_dm_d   = sel_dm_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
      rr_last_dm_d = rr_last_dm_q;
`else
      starve_d     = starve_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               state_d  = S_ACCESS;
               sel_dm_d = grant_dm;
               we_d     = grant_dm && bus.dm_we;
               addr_d   = grant_dm ? bus.dm_addr : bus.if_addr;
               wdata_d  = bus.dm_wdata;
`ifdef MEM_ARB_RR_EN
               rr_last_dm_d = grant_dm;
`else
               if (!grant_dm || !bus.if_req) starve_d = '0;
               else if (starve_q != LIM)     starve_d = starve_q + 1'b1;
`endif
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
            if (!we_q) begin
               if (sel_dm_q) dm_rdata_d = bus.mem_data_out;
               else          if_rdata_d = bus.mem_data_out;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sel_dm_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         rr_last_dm_q <= 1'b1;
`else
         starve_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         sel_dm_q   <= sel_dm_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
         rr_last_dm_q <= rr_last_dm_d;
`else
         starve_q     <= starve_d;
`endif
      end
   end

   // Bus outputs decode straight from the state register so an async reset clears them at once.
   always_comb begin
      bus.mem_address  = '0;
      bus.mem_read_en  = 1'b0;
      bus.mem_write_en = 1'b0;
      bus.mem_data_in  = '0;
      if (state_q == S_ACCESS) begin
         bus.mem_address  = addr_q;
         bus.mem_read_en  = !we_q;
         bus.mem_write_en = we_q;
         if (we_q) bus.mem_data_in = wdata_q;
      end
      bus.if_ack   = (state_q == S_RESP) && !sel_dm_q;
      bus.dm_ack   = (state_q == S_RESP) && sel_dm_q;
      bus.busy     = (state_q != S_IDLE);
      bus.if_rdata = if_rdata_q;
      bus.dm_rdata = dm_rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus ();

   mem_port_arbiter #(.ADDR_W(13), .DATA_W(16), .STARVE_LIMIT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- memory device ----------------
   logic [15:0] mem    [8192];
   bit          mem_wr [8192];
   logic        pl_en = 1'b0;
   logic [12:0] pl_addr = '0;
   logic [15:0] pl_data = '0;

   function automatic logic [15:0] init_val(input logic [12:0] a);
      return {a, 3'b101} ^ 16'h3C96;
   endfunction

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr]    <= pl_data;
         mem_wr[pl_addr] <= 1'b1;
      end else if (bus.mem_write_en) begin
         mem[bus.mem_address]    <= bus.mem_data_in;
         mem_wr[bus.mem_address] <= 1'b1;
      end
   end

   assign bus.mem_data_out = mem_wr[bus.mem_address] ? mem[bus.mem_address] : init_val(bus.mem_address);

   // ---------------- reference model ----------------
   typedef struct {bit dm; bit we; logic [12:0] addr; logic [15:0] wdata; logic [15:0] rdata; int ack_n;} txn_t;
   typedef struct {bit dm; int n;} ack_t;

   txn_t        q[$];
   ack_t        ack_log[$];
   logic [15:0] sh    [8192];
   bit          sh_wr [8192];
   int          n = 0;
   int          free_n = 0;
   int          starve = 0;
   bit          rr_dm = 1'b1;
   logic [15:0] exp_if = '0;
   logic [15:0] exp_dm = '0;
   int          wr_cnt = 0;

   function automatic logic [15:0] sh_rd(input logic [12:0] a);
      return sh_wr[a] ? sh[a] : init_val(a);
   endfunction

   always @(negedge clk) begin
      txn_t t;
      bit   active, in_acc, in_resp, win_dm;
      n++;
      if (rst) begin
         q.delete();
         free_n = 0; starve = 0; rr_dm = 1'b1; exp_if = '0; exp_dm = '0;
      end else begin
         if (bus.mem_write_en) wr_cnt++;
         if (bus.if_ack) ack_log.push_back('{dm: 1'b0, n: n});
         if (bus.dm_ack) ack_log.push_back('{dm: 1'b1, n: n});
         active  = (q.size() > 0);
         in_acc  = active && (n == q[0].ack_n - 1);
         in_resp = active && (n == q[0].ack_n);
         total++;
         if (bus.busy !== active) begin
            bad++; $display("FAIL model_busy n=%0d got=%b exp=%b", n, bus.busy, active);
         end
         total++;
         if (in_acc) begin
            t = q[0];
            if (bus.mem_address !== t.addr || bus.mem_read_en !== !t.we || bus.mem_write_en !== t.we ||
                (t.we && bus.mem_data_in !== t.wdata)) begin
               bad++;
               $display("FAIL model_access n=%0d got a=%h r=%b w=%b d=%h exp a=%h we=%b d=%h", n,
                        bus.mem_address, bus.mem_read_en, bus.mem_write_en, bus.mem_data_in, t.addr, t.we, t.wdata);
            end
            if (t.we) begin sh[t.addr] = t.wdata; sh_wr[t.addr] = 1'b1; end
            else t.rdata = sh_rd(t.addr);
            q[0] = t;
         end else if (bus.mem_address !== '0 || bus.mem_read_en !== 1'b0 ||
                      bus.mem_write_en !== 1'b0 || bus.mem_data_in !== '0) begin
            bad++;
            $display("FAIL model_mem_idle n=%0d got a=%h r=%b w=%b d=%h exp all 0", n,
                     bus.mem_address, bus.mem_read_en, bus.mem_write_en, bus.mem_data_in);
         end
         total++;
         if (bus.if_ack !== (in_resp && !q[0].dm) || bus.dm_ack !== (in_resp && q[0].dm)) begin
            bad++;
            $display("FAIL model_ack n=%0d got if=%b dm=%b exp if=%b dm=%b", n, bus.if_ack, bus.dm_ack,
                     in_resp && !q[0].dm, in_resp && q[0].dm);
         end
         if (in_resp) begin
            t = q.pop_front();
            if (!t.we) begin
               if (t.dm) exp_dm = t.rdata; else exp_if = t.rdata;
            end
         end
         total++;
         if (bus.if_rdata !== exp_if || bus.dm_rdata !== exp_dm) begin
            bad++;
            $display("FAIL model_rdata n=%0d got if=%h dm=%h exp if=%h dm=%h", n, bus.if_rdata, bus.dm_rdata, exp_if, exp_dm);
         end
         total++;
         if ((bus.if_ack && bus.dm_ack) || (bus.mem_read_en && bus.mem_write_en)) begin
            bad++; $display("FAIL exclusive n=%0d got acks=%b%b rw=%b%b exp never both", n,
                            bus.if_ack, bus.dm_ack, bus.mem_read_en, bus.mem_write_en);
         end
         // Requests seen now are the ones the next edge samples.
         if (n >= free_n && (bus.if_req || bus.dm_req)) begin
`ifdef MEM_ARB_RR_EN
            win_dm = (bus.if_req && bus.dm_req) ? !rr_dm : bus.dm_req;
            rr_dm  = win_dm;
`else
            win_dm = (bus.if_req && bus.dm_req) ? (starve != 3) : bus.dm_req;
            if (win_dm && bus.if_req) starve = (starve == 3) ? 3 : starve + 1;
            else                      starve = 0;
`endif
            t.dm    = win_dm;
            t.we    = win_dm && bus.dm_we;
            t.addr  = win_dm ? bus.dm_addr : bus.if_addr;
            t.wdata = bus.dm_wdata;
            t.rdata = '0;
            t.ack_n = n + 2;
            q.push_back(t);
            free_n = n + 3;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      rst = 1'b1; cyc(); cyc(); rst = 1'b0;
   endtask

   task automatic dm_txn(input bit we, input logic [12:0] a, input logic [15:0] d, output int lat);
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = a; bus.dm_wdata = d; lat = -1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         if (bus.dm_ack) begin lat = i; break; end
      end
      bus.dm_req = 1'b0;
   endtask

   task automatic if_txn(input logic [12:0] a, output int lat);
      bus.if_req = 1'b1; bus.if_addr = a; lat = -1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         if (bus.if_ack) begin lat = i; break; end
      end
      bus.if_req = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bit pre_wr;
      cyc();
      total++;
      if (bus.if_ack !== 0 || bus.dm_ack !== 0 || bus.busy !== 0 || bus.if_rdata !== '0 || bus.dm_rdata !== '0 ||
          bus.mem_address !== '0 || bus.mem_read_en !== 0 || bus.mem_write_en !== 0 || bus.mem_data_in !== '0) begin
         bad++; $display("FAIL reset_state got busy=%b acks=%b%b exp all 0", bus.busy, bus.if_ack, bus.dm_ack);
      end
      rst = 1'b0;
      cyc();
      pre_wr = mem_wr[13'h010];
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 13'h010; bus.dm_wdata = 16'hA5A5;
      cyc();
      total++;
      if (bus.mem_write_en !== 1'b1) begin
         bad++; $display("FAIL reset_pre_write got=%b exp=1", bus.mem_write_en);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus.mem_write_en !== 0 || bus.busy !== 0 || bus.dm_ack !== 0 || bus.mem_address !== '0 || bus.mem_read_en !== 0) begin
         bad++; $display("FAIL reset_abort got w=%b busy=%b ack=%b exp 0", bus.mem_write_en, bus.busy, bus.dm_ack);
      end
      #2 rst = 1'b0; bus.dm_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         total++;
         if (bus.dm_ack !== 0 || bus.if_ack !== 0) begin
            bad++; $display("FAIL reset_no_ack got dm=%b if=%b exp 0", bus.dm_ack, bus.if_ack);
         end
      end
      total++;
      if (mem_wr[13'h010] !== pre_wr) begin
         bad++; $display("FAIL reset_no_store got written=%b exp=%b", mem_wr[13'h010], pre_wr);
      end
   endtask

   task automatic test_if_read();
      int lat;
      pl_en = 1'b1; pl_addr = 13'h005; pl_data = 16'h1234;
      sh[13'h005] = 16'h1234; sh_wr[13'h005] = 1'b1;
      cyc(); pl_en = 1'b0;
      ack_log.delete();
      if_txn(13'h005, lat);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL if_latency got=%0d exp=2", lat); end
      total++;
      if (bus.if_rdata !== 16'h1234) begin bad++; $display("FAIL if_rdata got=%h exp=1234", bus.if_rdata); end
      cyc(); cyc();
      total++;
      if (ack_log.size() != 1 || ack_log[0].dm !== 1'b0) begin
         bad++; $display("FAIL if_only_ack got entries=%0d exp 1 IF ack", ack_log.size());
      end
   endtask

   task automatic test_store_load();
      int lat, w0;
      w0 = wr_cnt;
      dm_txn(1'b1, 13'h064, 16'hBEEF, lat);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL store_latency got=%0d exp=2", lat); end
      cyc();
      total++;
      if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL store_pulses got=%0d exp=1", wr_cnt - w0); end
      total++;
      if (bus.dm_rdata !== 16'h0000) begin bad++; $display("FAIL store_keeps_rdata got=%h exp=0000", bus.dm_rdata); end
      dm_txn(1'b0, 13'h064, 16'h0000, lat);
      total++;
      if (lat !== 2 || bus.dm_rdata !== 16'hBEEF) begin
         bad++; $display("FAIL load_rdata got lat=%0d data=%h exp lat=2 data=beef", lat, bus.dm_rdata);
      end
      cyc();
   endtask

   task automatic test_conflict();
      int li, ld;
      bit exp_first_dm;
`ifdef MEM_ARB_RR_EN
      exp_first_dm = 1'b0;
`else
      exp_first_dm = 1'b1;
`endif
      do_reset();
      ack_log.delete();
      fork
         if_txn(13'h007, li);
         dm_txn(1'b0, 13'h009, 16'h0, ld);
      join
      cyc();
      total++;
      if (ack_log.size() != 2 || ack_log[0].dm !== exp_first_dm || ack_log[1].dm !== !exp_first_dm) begin
         bad++; $display("FAIL conflict_order got entries=%0d exp first_dm=%b", ack_log.size(), exp_first_dm);
      end else begin
         total++;
         if (ack_log[1].n - ack_log[0].n != 3) begin
            bad++; $display("FAIL conflict_gap got=%0d exp=3", ack_log[1].n - ack_log[0].n);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit exp_seq[8];
      do_reset();
      ack_log.delete();
      bus.dm_we = 1'b0; bus.dm_addr = 13'h020; bus.if_addr = 13'h021;
`ifdef MEM_ARB_RR_EN
      for (int i = 0; i < 8; i++) exp_seq[i] = (i % 2 == 0);
      bus.dm_req = 1'b1; cyc(); bus.if_req = 1'b1;
`else
      for (int i = 0; i < 8; i++) exp_seq[i] = (i % 4 != 3);
      bus.dm_req = 1'b1; bus.if_req = 1'b1;
`endif
      for (int i = 0; i < 80 && ack_log.size() < 8; i++) cyc();
      bus.dm_req = 1'b0; bus.if_req = 1'b0;
      total++;
      if (ack_log.size() < 8) begin
         bad++; $display("FAIL b2b_timeout got=%0d exp=8 grants", ack_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (ack_log[i].dm !== exp_seq[i]) begin
               bad++; $display("FAIL b2b_order idx=%0d got dm=%b exp dm=%b", i, ack_log[i].dm, exp_seq[i]);
            end
            if (i > 0) begin
               total++;
               if (ack_log[i].n - ack_log[i-1].n != 3) begin
                  bad++; $display("FAIL b2b_gap idx=%0d got=%0d exp=3", i, ack_log[i].n - ack_log[i-1].n);
               end
            end
         end
      end
      repeat (4) cyc();
   endtask

   task automatic test_random();
      do_reset();
      fork
         for (int i = 0; i < 400; i++) begin
            cyc();
            if (bus.if_ack) begin
               if ($urandom_range(0, 1) == 0) bus.if_req = 1'b0;
               bus.if_addr = 13'($urandom_range(0, 15));
            end else if (!bus.if_req) begin
               if ($urandom_range(0, 2) == 0) begin bus.if_req = 1'b1; bus.if_addr = 13'($urandom_range(0, 15)); end
            end else if ($urandom_range(0, 3) == 0) bus.if_addr = 13'($urandom_range(0, 15));
         end
         for (int i = 0; i < 400; i++) begin
            cyc();
            if (bus.dm_ack || !bus.dm_req) begin
               if (bus.dm_ack && $urandom_range(0, 1) == 0) bus.dm_req = 1'b0;
               else if (bus.dm_ack || $urandom_range(0, 2) == 0) begin
                  bus.dm_req = 1'b1; bus.dm_we = 1'($urandom_range(0, 1));
                  bus.dm_addr = 13'($urandom_range(0, 15)); bus.dm_wdata = 16'($urandom);
               end
            end else if ($urandom_range(0, 3) == 0) begin
               bus.dm_addr = 13'($urandom_range(0, 15)); bus.dm_wdata = 16'($urandom);
            end
         end
      join
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      repeat (6) cyc();
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL random_drain got busy=%b exp=0", bus.busy); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      test_reset();
      test_if_read();
      test_store_load();
      test_conflict();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
